ascon_ct_fifo: RTL and testbench

Downstream capture stage for the ASCON AEAD core. Consumes 64-bit ciphertext/plaintext blocks (`CTblock`/`CTv`) and the 128-bit tag (`Tag`/`Tv`) as the core produces them. Masks each block to its valid byte count, splits it into big-endian 32-bit words and buffers them in a FIFO so a bus-side reader can drain output at its own pace. Also tracks the total output byte count and holds the tag for word-wise readout.

---
 rtl/ascon_ct_fifo.sv | 119 +++++++++++
 tb/tb_ascon_ct_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_ct_fifo.sv
// Output capture stage for the ASCON core: masks ciphertext blocks to their byte count,
// splits them into big-endian 32-bit words in a show-ahead FIFO, and holds the tag.
module ascon_ct_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     clear,
  input  logic [63:0]              CTblock,
  input  logic                     CTv,
  input  logic [3:0]               ct_bytes,
  input  logic [127:0]             Tag,
  input  logic                     Tv,
  output logic                     ct_ready,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              byte_count,
  input  logic [1:0]               tag_sel,
  output logic [31:0]              tag_word,
  output logic                     tag_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [LW-1:0]  cnt;
  logic [LW-1:0]  free;
  logic [127:0]   tag_reg;
  logic [3:0]     n;
  logic [63:0]    kill_mask;
  logic [63:0]    masked;
  logic [1:0]     need;
  logic [1:0]     nwr;
  logic           accept;
  logic           reject;
  logic           pop;
  logic [16:0]    bc_sum;

  assign n = (ct_bytes > 4'd8) ? 4'd8 : ct_bytes;

  // Bytes at index >= n sit in the low bits; shifting an all-ones mask right by 8*n selects them.
  assign kill_mask = 64'hFFFF_FFFF_FFFF_FFFF >> {n, 3'b000};
  assign masked    = CTblock & ~kill_mask;

  always_comb begin
    need = 2'd0;
    if (n == 4'd0)       need = 2'd0;
    else if (n <= 4'd4)  need = 2'd1;
    else                 need = 2'd2;
  end

  // Free space is judged on registered level only; a same-cycle pop never makes room.
  assign free     = LW'(DEPTH) - cnt;
  assign accept   = CTv && (need != 2'd0) && (free >= LW'(need));
  assign reject   = CTv && (need != 2'd0) && !accept;
  assign nwr      = accept ? need : 2'd0;
  assign rd_valid = (cnt != '0);
  assign pop      = rd_en && rd_valid;
  assign ct_ready = (free >= LW'(2));
  assign level    = cnt;
  assign rd_data  = rd_valid ? mem[rptr] : 32'd0;
  assign bc_sum   = {1'b0, byte_count} + 17'(n);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      overflow   <= 1'b0;
      byte_count <= 16'd0;
      tag_reg    <= 128'd0;
      tag_valid  <= 1'b0;
    end else if (clear) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      overflow   <= 1'b0;
      byte_count <= 16'd0;
      tag_reg    <= 128'd0;
      tag_valid  <= 1'b0;
    end else begin
      if (accept) begin
        wptr       <= wptr + AW'(need);
        byte_count <= bc_sum[16] ? 16'hFFFF : bc_sum[15:0];
      end
      if (reject) overflow <= 1'b1;
      if (pop) rptr <= rptr + AW'(1);
      cnt <= cnt + LW'(nwr) - LW'(pop);
      if (Tv) begin
        tag_reg   <= Tag;
        tag_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && !clear && accept) begin
      mem[wptr] <= masked[63:32];
      if (need == 2'd2) mem[wptr + AW'(1)] <= masked[31:0];
    end
  end

  always_comb begin
    tag_word = 32'd0;
    case (tag_sel)
      2'd0:    tag_word = tag_reg[127:96];
      2'd1:    tag_word = tag_reg[95:64];
      2'd2:    tag_word = tag_reg[63:32];
      default: tag_word = tag_reg[31:0];
    endcase
  end

endmodule

// File: tb/tb_ascon_ct_fifo.sv
// Bench for ascon_ct_fifo: directed blocks checked every cycle against a queue model,
// plus hand-computed literal expectations at key points.
module tb_ascon_ct_fifo;

  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [63:0]   CTblock = 64'd0;
  logic          CTv = 1'b0;
  logic [3:0]    ct_bytes = 4'd0;
  logic [127:0]  Tag = 128'd0;
  logic          Tv = 1'b0;
  logic          ct_ready;
  logic          rd_en = 1'b0;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic          overflow;
  logic [15:0]   byte_count;
  logic [1:0]    tag_sel = 2'd0;
  logic [31:0]   tag_word;
  logic          tag_valid;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  ascon_ct_fifo #(.DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .clear(clear),
    .CTblock(CTblock), .CTv(CTv), .ct_bytes(ct_bytes),
    .Tag(Tag), .Tv(Tv), .ct_ready(ct_ready),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .level(level), .overflow(overflow), .byte_count(byte_count),
    .tag_sel(tag_sel), .tag_word(tag_word), .tag_valid(tag_valid)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0]  q_m[$];
  int           bc_m = 0;
  bit           ovf_m = 1'b0;
  logic [127:0] tag_m = 128'd0;
  bit           tv_m = 1'b0;
  int           m_n, m_need, m_free;
  logic [63:0]  m_blk;

  always @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      q_m.delete();
      bc_m = 0; ovf_m = 1'b0; tag_m = 128'd0; tv_m = 1'b0;
    end else begin
      m_n    = (ct_bytes > 8) ? 8 : int'(ct_bytes);
      m_need = (m_n == 0) ? 0 : ((m_n <= 4) ? 1 : 2);
      m_free = DEPTH - q_m.size();
      if (rd_en && q_m.size() > 0) void'(q_m.pop_front());
      if (CTv && m_need > 0) begin
        if (m_free >= m_need) begin
          m_blk = 64'd0;
          for (int b = 0; b < 8; b++)
            if (b < m_n) m_blk[63-8*b -: 8] = CTblock[63-8*b -: 8];
          q_m.push_back(m_blk[63:32]);
          if (m_need == 2) q_m.push_back(m_blk[31:0]);
          bc_m = (bc_m + m_n > 65535) ? 65535 : bc_m + m_n;
        end else begin
          ovf_m = 1'b1;
        end
      end
      if (Tv) begin tag_m = Tag; tv_m = 1'b1; end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 128'(level), 128'(q_m.size()));
      chk("rd_valid", 128'(rd_valid), 128'(q_m.size() > 0));
      chk("rd_data", 128'(rd_data), 128'(q_m.size() > 0 ? q_m[0] : 32'd0));
      chk("ct_ready", 128'(ct_ready), 128'(DEPTH - q_m.size() >= 2));
      chk("overflow", 128'(overflow), 128'(ovf_m));
      chk("byte_count", 128'(byte_count), 128'(bc_m));
      chk("tag_valid", 128'(tag_valid), 128'(tv_m));
      chk("tag_word", 128'(tag_word), 128'(tag_m[127-32*int'(tag_sel) -: 32]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic blk(input logic [63:0] d, input logic [3:0] nb, input bit pop);
    CTblock = d; ct_bytes = nb; CTv = 1'b1; rd_en = pop;
    tick();
    CTv = 1'b0; rd_en = 1'b0;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ct_ready"}, 128'(ct_ready), 128'(1));
    chk({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
    chk({tag, "_rd_data"}, 128'(rd_data), 128'(0));
    chk({tag, "_level"}, 128'(level), 128'(0));
    chk({tag, "_overflow"}, 128'(overflow), 128'(0));
    chk({tag, "_byte_count"}, 128'(byte_count), 128'(0));
    chk({tag, "_tag_valid"}, 128'(tag_valid), 128'(0));
    for (int s = 0; s < 4; s++) begin
      tag_sel = 2'(s);
      #1 chk({tag, "_tag_word"}, 128'(tag_word), 128'(0));
    end
  endtask

  logic [31:0] tag_exp [4];

  initial begin
    tag_exp[0] = 32'h01234567; tag_exp[1] = 32'hFEDCBA98;
    tag_exp[2] = 32'h76543210; tag_exp[3] = 32'h89ABCDEF;

    // Reset / idle
    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk_en = 1'b1;

    // Full block
    blk(64'h0011223344556677, 4'd8, 1'b0);
    chk("full_level", 128'(level), 128'(2));
    chk("full_w0", 128'(rd_data), 128'(32'h00112233));
    pop1();
    chk("full_w1", 128'(rd_data), 128'(32'h44556677));
    chk("full_bc", 128'(byte_count), 128'(8));
    pop1();

    // Partial blocks
    do_clear();
    blk(64'hAABBCCDDEEFF0102, 4'd5, 1'b0);
    blk(64'hAABBCCDDEEFF0102, 4'd3, 1'b0);
    blk(64'hAABBCCDDEEFF0102, 4'd0, 1'b0);
    chk("part_level", 128'(level), 128'(3));
    chk("part_bc", 128'(byte_count), 128'(8));
    chk("part_w0", 128'(rd_data), 128'(32'hAABBCCDD));
    pop1();
    chk("part_w1", 128'(rd_data), 128'(32'hEE000000));
    pop1();
    chk("part_w2", 128'(rd_data), 128'(32'hAABBCC00));
    pop1();
    blk(64'h0102030405060708, 4'd12, 1'b0);
    chk("clamp_bc", 128'(byte_count), 128'(16));
    chk("clamp_w0", 128'(rd_data), 128'(32'h01020304));
    pop1();
    chk("clamp_w1", 128'(rd_data), 128'(32'h05060708));
    pop1();
    blk(64'hDEADBEEFCAFEF00D, 4'd4, 1'b0);
    chk("four_w0", 128'(rd_data), 128'(32'hDEADBEEF));
    pop1();

    // Overflow and the one-word-free boundary
    do_clear();
    for (int i = 0; i < 8; i++) blk({8{8'(i + 1)}}, 4'd8, 1'b0);
    chk("ovf_level_full", 128'(level), 128'(16));
    chk("ovf_ready_full", 128'(ct_ready), 128'(0));
    blk(64'hFFFFFFFFFFFFFFFF, 4'd8, 1'b0);
    chk("ovf_flag", 128'(overflow), 128'(1));
    chk("ovf_bc", 128'(byte_count), 128'(64));
    blk(64'h9900000000000000, 4'd1, 1'b1);
    chk("ovf_pop_no_room", 128'(level), 128'(15));
    chk("ovf_ready_15", 128'(ct_ready), 128'(0));
    blk(64'h7700000000000000, 4'd1, 1'b0);
    chk("ovf_last_word", 128'(level), 128'(16));
    chk("ovf_bc_65", 128'(byte_count), 128'(65));
    for (int i = 0; i < 16; i++) pop1();
    do_clear();
    chk("clr_overflow", 128'(overflow), 128'(0));
    chk("clr_level", 128'(level), 128'(0));

    // Simultaneous push and pop, pop while empty
    blk(64'h1111111122222222, 4'd8, 1'b0);
    blk(64'h3333333344444444, 4'd4, 1'b0);
    blk(64'h4444444455555555, 4'd8, 1'b1);
    chk("sim_level", 128'(level), 128'(4));
    chk("sim_w0", 128'(rd_data), 128'(32'h22222222));
    pop1();
    chk("sim_w1", 128'(rd_data), 128'(32'h33333333));
    pop1(); pop1(); pop1();
    chk("sim_empty_data", 128'(rd_data), 128'(0));
    pop1();
    chk("sim_empty_level", 128'(level), 128'(0));
    chk("sim_empty_valid", 128'(rd_valid), 128'(0));

    // Pointer wrap over more than 3*DEPTH words
    do_clear();
    for (int i = 0; i < 26; i++) begin
      for (int g = 0; g < 4 && q_m.size() > DEPTH - 2; g++) pop1();
      blk({32'hA5000000 | 32'(i), 32'h5A000000 | 32'(i)}, 4'd8, 1'b1);
    end
    for (int g = 0; g < 2 * DEPTH && q_m.size() > 0; g++) pop1();
    chk("wrap_drained", 128'(level), 128'(0));

    // Tag capture alongside a block
    do_clear();
    Tag = 128'h01234567_FEDCBA98_76543210_89ABCDEF;
    Tv = 1'b1; CTblock = 64'hCAFEBABE00000000; ct_bytes = 4'd4; CTv = 1'b1;
    #1 chk("tag_pre", 128'(tag_valid), 128'(0));
    tick();
    Tv = 1'b0; CTv = 1'b0;
    chk("tag_valid", 128'(tag_valid), 128'(1));
    chk("tag_ct_word", 128'(rd_data), 128'(32'hCAFEBABE));
    for (int s = 0; s < 4; s++) begin
      tag_sel = 2'(s);
      #1 chk("tag_word_lit", 128'(tag_word), 128'(tag_exp[s]));
    end
    Tag = 128'h0; Tv = 1'b1; CTv = 1'b1; ct_bytes = 4'd8; rd_en = 1'b1; clear = 1'b1;
    tick();
    Tv = 1'b0; CTv = 1'b0; rd_en = 1'b0; clear = 1'b0;
    chk_reset_outputs("clr_prio");

    // Byte counter saturation
    for (int i = 0; i < 8200; i++) begin
      blk({16'(i), 16'h1234, 16'(~i), 16'h5678}, 4'd8, 1'b1);
      pop1();
    end
    chk("sat_bc", 128'(byte_count), 128'(16'hFFFF));
    chk("sat_ovf", 128'(overflow), 128'(0));

    // Mid-run asynchronous reset
    Tag = 128'hFFFF; Tv = 1'b1;
    blk(64'h0102030405060708, 4'd8, 1'b0);
    Tv = 1'b0;
    blk(64'h0102030405060708, 4'd8, 1'b0);
    rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_level", 128'(level), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
